// File: rtl/pcache_line_adapter_pkg.sv
// Shared types and default geometry for the pipelined-cache line adapter.
// Contents:
//   PLA_* localparams  default line/beat/address widths, beat count and line offset bits
//   pla_state_t        adapter FSM states
//   pla_beat_bits()    width of a beat index (at least one bit)
package pcache_line_adapter_pkg;

  localparam int unsigned PLA_LINE_WIDTH  = 256;
  localparam int unsigned PLA_BURST_WIDTH = 64;
  localparam int unsigned PLA_ADDR_WIDTH  = 32;
  localparam int unsigned PLA_BEATS       = PLA_LINE_WIDTH / PLA_BURST_WIDTH;
  localparam int unsigned PLA_OFS         = $clog2(PLA_LINE_WIDTH / 8);

  typedef enum logic [1:0] {
    StIdle,
    StRdBurst,
    StWrBurst,
    StResp
  } pla_state_t;

  function automatic int unsigned pla_beat_bits(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/pcache_line_adapter_if.sv
// Bundle of the cache-side and memory-side signals of the line adapter.
// Signal names carry the direction as seen from the adapter.
// Modports:
//   slave   the adapter: takes cache requests and memory beats, drives responses/bursts
//   master  the environment (cache miss stage plus physical memory)
interface pcache_line_adapter_if #(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned BURST_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH  = 32
) ();

  logic [ADDR_WIDTH-1:0]  c_addr_i;
  logic                   c_read_i;
  logic                   c_write_i;
  logic [LINE_WIDTH-1:0]  c_line_i;
  logic [LINE_WIDTH-1:0]  c_line_o;
  logic                   c_resp_o;
  logic [ADDR_WIDTH-1:0]  m_addr_o;
  logic                   m_read_o;
  logic                   m_write_o;
  logic [BURST_WIDTH-1:0] m_burst_o;
  logic [BURST_WIDTH-1:0] m_burst_i;
  logic                   m_resp_i;

  modport slave (
    input  c_addr_i, c_read_i, c_write_i, c_line_i, m_burst_i, m_resp_i,
    output c_line_o, c_resp_o, m_addr_o, m_read_o, m_write_o, m_burst_o
  );

  modport master (
    output c_addr_i, c_read_i, c_write_i, c_line_i, m_burst_i, m_resp_i,
    input  c_line_o, c_resp_o, m_addr_o, m_read_o, m_write_o, m_burst_o
  );

endinterface

// File: rtl/pcache_line_adapter_line_burst_buffer.sv
// One cache line of storage, addressable per memory beat.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high clear
//   we_i          write din_i into the beat selected by beat_i
//   beat_i        beat index for both write and dout_o
//   din_i         beat write data
//   load_i        load the whole line from line_i (wins over we_i)
//   line_i        full-line load data
//   dout_o        beat selected by beat_i
//   line_o        full line contents
module pcache_line_adapter_line_burst_buffer
  import pcache_line_adapter_pkg::*;
#(
  parameter int unsigned LineWidth  = 256,
  parameter int unsigned BurstWidth = 64
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             we_i,
  input  logic [pla_beat_bits(LineWidth/BurstWidth)-1:0]   beat_i,
  input  logic [BurstWidth-1:0]                            din_i,
  input  logic                                             load_i,
  input  logic [LineWidth-1:0]                             line_i,
  output logic [BurstWidth-1:0]                            dout_o,
  output logic [LineWidth-1:0]                             line_o
);

  logic [LineWidth-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (load_i) begin
      line_d = line_i;
    end else if (we_i) begin
      line_d[beat_i*BurstWidth +: BurstWidth] = din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign dout_o = line_q[beat_i*BurstWidth +: BurstWidth];
  assign line_o = line_q;

endmodule

// File: rtl/pcache_line_adapter.sv
// Memory-side responder for the pipelined cache: serves one full-line fill or writeback
// as a BEATS-beat burst on the physical-memory port, then pulses c_resp_o for one cycle.
// Ports:
//   clk   clock, all state on posedge
//   rst   synchronous active-high reset; abandons any burst without a response
//   bus   pcache_line_adapter_if.slave: cache request/response and memory burst signals
// Optional feature: define FILL_BUFFER_HIT_EN to answer a repeated read of the last filled
// line straight from the line buffer, without a memory burst.
module pcache_line_adapter
  import pcache_line_adapter_pkg::*;
#(
  parameter int unsigned LINE_WIDTH  = PLA_LINE_WIDTH,
  parameter int unsigned BURST_WIDTH = PLA_BURST_WIDTH,
  parameter int unsigned ADDR_WIDTH  = PLA_ADDR_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  pcache_line_adapter_if.slave bus
);

  localparam int unsigned BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int unsigned OFS   = $clog2(LINE_WIDTH / 8);
  localparam int unsigned BeatW = pla_beat_bits(BEATS);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OfsMask = ADDR_WIDTH'((64'd1 << OFS) - 64'd1);

  pla_state_t              state_q;
  logic [BeatW-1:0]        beat_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    m_read_q, m_write_q, c_resp_q;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    buf_load, buf_we, last_ack, hit;
  logic [BURST_WIDTH-1:0]  beat_data;
  logic [LINE_WIDTH-1:0]   line_data;

  assign req_addr = bus.c_addr_i & ~OfsMask;
  assign last_ack = bus.m_resp_i && (beat_q == LastBeat);
  // Writeback data is captured on acceptance so the cache may reuse c_line_i afterwards.
  assign buf_load = (state_q == StIdle) && bus.c_write_i;
  assign buf_we   = (state_q == StRdBurst) && bus.m_resp_i;

  pcache_line_adapter_line_burst_buffer #(
    .LineWidth (LINE_WIDTH),
    .BurstWidth(BURST_WIDTH)
  ) u_line_buf (
    .clk_i (clk),
    .rst_i (rst),
    .we_i  (buf_we),
    .beat_i(beat_q),
    .din_i (bus.m_burst_i),
    .load_i(buf_load),
    .line_i(bus.c_line_i),
    .dout_o(beat_data),
    .line_o(line_data)
  );

`ifdef FILL_BUFFER_HIT_EN
  logic [ADDR_WIDTH-1:0] tag_q;
  logic                  valid_q;

  assign hit = valid_q && (req_addr == tag_q);

  // The buffer is shared with writebacks, so any accepted write overwrites the filled line
  // and must drop validity, not only a write to the tagged line.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if (state_q == StIdle) begin
      if (bus.c_write_i) begin
        valid_q <= 1'b0;
      end else if (bus.c_read_i && !hit) begin
        tag_q   <= req_addr;
        valid_q <= 1'b0;
      end
    end else if ((state_q == StRdBurst) && last_ack) begin
      valid_q <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      addr_q    <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      c_resp_q  <= 1'b0;
    end else begin
      c_resp_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          beat_q <= '0;
          // Write first: a concurrent read stays pending until the next idle cycle.
          if (bus.c_write_i) begin
            addr_q    <= req_addr;
            m_write_q <= 1'b1;
            state_q   <= StWrBurst;
          end else if (bus.c_read_i) begin
            addr_q <= req_addr;
            if (hit) begin
              c_resp_q <= 1'b1;
              state_q  <= StResp;
            end else begin
              m_read_q <= 1'b1;
              state_q  <= StRdBurst;
            end
          end
        end
        StRdBurst: begin
          if (last_ack) begin
            beat_q   <= '0;
            m_read_q <= 1'b0;
            c_resp_q <= 1'b1;
            state_q  <= StResp;
          end else if (bus.m_resp_i) begin
            beat_q <= beat_q + 1'b1;
          end
        end
        StWrBurst: begin
          if (last_ack) begin
            beat_q    <= '0;
            m_write_q <= 1'b0;
            c_resp_q  <= 1'b1;
            state_q   <= StResp;
          end else if (bus.m_resp_i) begin
            beat_q <= beat_q + 1'b1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.m_addr_o  = addr_q;
  assign bus.m_read_o  = m_read_q;
  assign bus.m_write_o = m_write_q;
  assign bus.c_resp_o  = c_resp_q;
  assign bus.m_burst_o = beat_data;
  assign bus.c_line_o  = line_data;

endmodule

// File: tb/tb_pcache_line_adapter.sv
// Self-checking bench for pcache_line_adapter with a behavioural memory (optional ack gaps)
// and scoreboards of expected fill lines and expected writeback beats.
module tb_pcache_line_adapter;

  localparam int unsigned LW    = 256;
  localparam int unsigned BW    = 64;
  localparam int unsigned AW    = 32;
  localparam int unsigned BEATS = LW / BW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pcache_line_adapter_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  pcache_line_adapter #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [LW-1:0] exp_line_q[$];
  logic [BW-1:0] exp_beat_q[$];

  // Memory model state
  int            gap = 0;
  int            gap_cnt = 0;
  int            rd_beat = 0;
  logic [BW-1:0] rd_data[BEATS];
  bit            spurious = 1'b0;

  // Observations collected at each falling edge
  int            edges = 0;
  int            n_resp = 0;
  int            resp_edge = 0;
  int            rd_cycles = 0;
  int            wr_cycles = 0;
  int            rd_rise = -1;
  int            wr_rise = -1;
  int            onehot_err = 0;
  int            unstable = 0;
  logic [LW-1:0] resp_line = '0;
  logic [BW-1:0] wr_log[$];
  logic          prev_rd = 1'b0;
  logic          prev_wr = 1'b0;
  logic          prev_ack = 1'b0;
  logic [BW-1:0] prev_burst = '0;

  task automatic tick();
    @(negedge clk);
    edges++;
    if (bus.c_resp_o === 1'b1) begin
      n_resp++;
      resp_edge = edges;
      resp_line = bus.c_line_o;
    end
    if (int'(bus.m_read_o === 1'b1) + int'(bus.m_write_o === 1'b1) +
        int'(bus.c_resp_o === 1'b1) > 1) onehot_err++;
    if (bus.m_read_o === 1'b1) begin
      rd_cycles++;
      if (!prev_rd) rd_rise = edges;
    end
    if (bus.m_write_o === 1'b1) begin
      wr_cycles++;
      if (!prev_wr) wr_rise = edges;
      if (prev_wr && !prev_ack && (bus.m_burst_o !== prev_burst)) unstable++;
    end
    prev_rd    = (bus.m_read_o === 1'b1);
    prev_wr    = (bus.m_write_o === 1'b1);
    prev_burst = bus.m_burst_o;
    if ((bus.m_read_o === 1'b1) || (bus.m_write_o === 1'b1)) begin
      if (gap_cnt >= gap) begin
        bus.m_resp_i = 1'b1;
        gap_cnt = 0;
        if (bus.m_write_o === 1'b1) begin
          wr_log.push_back(bus.m_burst_o);
        end else begin
          bus.m_burst_i = rd_data[rd_beat % BEATS];
          rd_beat++;
        end
      end else begin
        bus.m_resp_i = 1'b0;
        gap_cnt++;
      end
    end else begin
      bus.m_resp_i  = spurious;
      bus.m_burst_i = spurious ? {$urandom(), $urandom()} : '0;
      gap_cnt = 0;
      rd_beat = 0;
    end
    prev_ack = bus.m_resp_i;
  endtask

  task automatic wait_resp(input int start_resp, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (n_resp > start_resp) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic set_rd_random();
    for (int i = 0; i < BEATS; i++) rd_data[i] = {$urandom(), $urandom()};
  endtask

  task automatic push_rd_exp();
    logic [LW-1:0] l;
    for (int i = 0; i < BEATS; i++) l[i*BW +: BW] = rd_data[i];
    exp_line_q.push_back(l);
  endtask

  task automatic push_wr_exp(input logic [LW-1:0] l);
    for (int i = 0; i < BEATS; i++) exp_beat_q.push_back(l[i*BW +: BW]);
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [LW-1:0] l);
    bus.c_addr_i  = a;
    bus.c_read_i  = rd;
    bus.c_write_i = wr;
    bus.c_line_i  = l;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++;
    if (bus.m_read_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_m_read: got %b want 0", bus.m_read_o);
    end
    n_cmp++;
    if (bus.m_write_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_m_write: got %b want 0", bus.m_write_o);
    end
    n_cmp++;
    if (bus.c_resp_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_c_resp: got %b want 0", bus.c_resp_o);
    end
    n_cmp++;
    if (bus.m_addr_o !== '0) begin
      n_bad++; $display("FAIL reset_m_addr: got %h want 0", bus.m_addr_o);
    end
    n_cmp++;
    if (bus.c_line_o !== '0) begin
      n_bad++; $display("FAIL reset_c_line: got %h want 0", bus.c_line_o);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.m_burst_o !== '0) begin
      n_bad++; $display("FAIL reset_m_burst: got %h want 0", bus.m_burst_o);
    end
  endtask

  task automatic test_read_zero_wait();
    int s, sr, rc0;
    bit to;
    logic [LW-1:0] e;
    gap = 0;
    for (int i = 0; i < BEATS; i++) rd_data[i] = {8{8'(8'h11 * (i + 1))}};
    push_rd_exp();
    s = edges; sr = n_resp; rc0 = rd_cycles;
    issue(1'b1, 1'b0, 32'h0000_1234, '0);
    tick();
    n_cmp++;
    if (bus.m_addr_o !== 32'h0000_1220) begin
      n_bad++; $display("FAIL rd_m_addr: got %h want 00001220", bus.m_addr_o);
    end
    n_cmp++;
    if (bus.m_read_o !== 1'b1) begin
      n_bad++; $display("FAIL rd_m_read: got %b want 1", bus.m_read_o);
    end
    wait_resp(sr, to);
    bus.c_read_i = 1'b0;
    n_cmp++;
    if (to) begin
      n_bad++; $display("FAIL rd_timeout: got no c_resp_o want one");
    end
    n_cmp++;
    if (resp_edge - s != BEATS + 1) begin
      n_bad++; $display("FAIL rd_latency: got %0d want %0d", resp_edge - s, BEATS + 1);
    end
    e = exp_line_q.pop_front();
    n_cmp++;
    if (resp_line !== e) begin
      n_bad++; $display("FAIL rd_line: got %h want %h", resp_line, e);
    end
    repeat (3) tick();
    n_cmp++;
    if (rd_cycles - rc0 != BEATS) begin
      n_bad++; $display("FAIL rd_cycles: got %0d want %0d", rd_cycles - rc0, BEATS);
    end
    n_cmp++;
    if (n_resp != sr + 1) begin
      n_bad++; $display("FAIL rd_resp_count: got %0d want %0d", n_resp - sr, 1);
    end
  endtask

  task automatic test_write_gaps();
    int s, sr, wc0;
    bit to;
    logic [LW-1:0] l;
    logic [BW-1:0] eb;
    gap = 2;
    l = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    wr_log.delete();
    push_wr_exp(l);
    s = edges; sr = n_resp; wc0 = wr_cycles; unstable = 0;
    issue(1'b0, 1'b1, 32'h0000_2468, l);
    tick();
    bus.c_line_i = ~l;
    n_cmp++;
    if (bus.m_addr_o !== 32'h0000_2460) begin
      n_bad++; $display("FAIL wr_m_addr: got %h want 00002460", bus.m_addr_o);
    end
    wait_resp(sr, to);
    bus.c_write_i = 1'b0;
    n_cmp++;
    if (to) begin
      n_bad++; $display("FAIL wr_timeout: got no c_resp_o want one");
    end
    n_cmp++;
    if (resp_edge - s != 3 * BEATS + 1) begin
      n_bad++; $display("FAIL wr_latency: got %0d want %0d", resp_edge - s, 3 * BEATS + 1);
    end
    repeat (3) tick();
    n_cmp++;
    if (wr_cycles - wc0 != 3 * BEATS) begin
      n_bad++; $display("FAIL wr_m_write_steady: got %0d want %0d", wr_cycles - wc0, 3 * BEATS);
    end
    n_cmp++;
    if (unstable != 0) begin
      n_bad++; $display("FAIL wr_burst_stable: got %0d changes want 0", unstable);
    end
    n_cmp++;
    if (wr_log.size() != BEATS) begin
      n_bad++; $display("FAIL wr_beat_count: got %0d want %0d", wr_log.size(), BEATS);
    end
    for (int i = 0; i < BEATS; i++) begin
      eb = exp_beat_q.pop_front();
      n_cmp++;
      if (wr_log.size() == 0 || wr_log[0] !== eb) begin
        n_bad++; $display("FAIL wr_beat%0d: got %h want %h", i,
                          (wr_log.size() == 0) ? 64'hx : wr_log[0], eb);
      end
      if (wr_log.size() != 0) void'(wr_log.pop_front());
    end
    n_cmp++;
    if (n_resp != sr + 1) begin
      n_bad++; $display("FAIL wr_resp_count: got %0d want %0d", n_resp - sr, 1);
    end
    gap = 0;
  endtask

  task automatic test_read_write_together();
    int sr, r1;
    bit to;
    logic [LW-1:0] l, e;
    logic [BW-1:0] eb;
    l = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    set_rd_random();
    wr_log.delete();
    push_wr_exp(l);
    push_rd_exp();
    sr = n_resp; rd_rise = -1; wr_rise = -1;
    issue(1'b1, 1'b1, 32'h0000_3044, l);
    wait_resp(sr, to);
    bus.c_write_i = 1'b0;
    r1 = resp_edge;
    n_cmp++;
    if (to || wr_rise < 0 || rd_rise >= 0) begin
      n_bad++; $display("FAIL both_write_first: got wr_rise=%0d rd_rise=%0d want write only",
                        wr_rise, rd_rise);
    end
    wait_resp(sr + 1, to);
    bus.c_read_i = 1'b0;
    n_cmp++;
    if (to || rd_rise != r1 + 2) begin
      n_bad++; $display("FAIL both_read_start: got %0d want %0d", rd_rise, r1 + 2);
    end
    e = exp_line_q.pop_front();
    n_cmp++;
    if (resp_line !== e) begin
      n_bad++; $display("FAIL both_read_line: got %h want %h", resp_line, e);
    end
    for (int i = 0; i < BEATS; i++) begin
      eb = exp_beat_q.pop_front();
      n_cmp++;
      if (wr_log.size() == 0 || wr_log[0] !== eb) begin
        n_bad++; $display("FAIL both_wr_beat%0d: want %h", i, eb);
      end
      if (wr_log.size() != 0) void'(wr_log.pop_front());
    end
    repeat (3) tick();
    n_cmp++;
    if (n_resp != sr + 2) begin
      n_bad++; $display("FAIL both_resp_count: got %0d want 2", n_resp - sr);
    end
  endtask

  task automatic test_reset_mid_burst();
    int s, sr;
    bit to;
    logic [LW-1:0] e;
    set_rd_random();
    sr = n_resp;
    issue(1'b1, 1'b0, 32'h0000_6010, '0);
    repeat (4) tick();
    rst = 1'b1;
    bus.c_read_i = 1'b0;
    tick();
    n_cmp++;
    if ({bus.m_read_o, bus.m_write_o, bus.c_resp_o} !== 3'b000) begin
      n_bad++; $display("FAIL rst_mid_ctrl: got %b want 000",
                        {bus.m_read_o, bus.m_write_o, bus.c_resp_o});
    end
    n_cmp++;
    if (bus.c_line_o !== '0 || bus.m_addr_o !== '0 || bus.m_burst_o !== '0) begin
      n_bad++; $display("FAIL rst_mid_data: got line=%h addr=%h want 0", bus.c_line_o,
                        bus.m_addr_o);
    end
    rst = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (n_resp != sr) begin
      n_bad++; $display("FAIL rst_mid_no_resp: got %0d want 0", n_resp - sr);
    end
    set_rd_random();
    push_rd_exp();
    s = edges;
    issue(1'b1, 1'b0, 32'h0000_6010, '0);
    wait_resp(sr, to);
    bus.c_read_i = 1'b0;
    tick();
    n_cmp++;
    if (to || resp_edge - s != BEATS + 1) begin
      n_bad++; $display("FAIL rst_fresh_latency: got %0d want %0d", resp_edge - s, BEATS + 1);
    end
    e = exp_line_q.pop_front();
    n_cmp++;
    if (resp_line !== e) begin
      n_bad++; $display("FAIL rst_fresh_line: got %h want %h", resp_line, e);
    end
  endtask

  task automatic test_spurious_idle();
    int s, sr, rc0, wc0;
    bit to;
    logic [LW-1:0] e;
    sr = n_resp; rc0 = rd_cycles; wc0 = wr_cycles;
    spurious = 1'b1;
    repeat (4) tick();
    spurious = 1'b0;
    n_cmp++;
    if (rd_cycles != rc0 || wr_cycles != wc0 || n_resp != sr) begin
      n_bad++; $display("FAIL spur_idle_activity: got rd=%0d wr=%0d resp=%0d want 0 0 0",
                        rd_cycles - rc0, wr_cycles - wc0, n_resp - sr);
    end
    set_rd_random();
    push_rd_exp();
    s = edges;
    issue(1'b1, 1'b0, 32'h0000_4000, '0);
    wait_resp(sr, to);
    bus.c_read_i = 1'b0;
    tick();
    n_cmp++;
    if (to || resp_edge - s != BEATS + 1) begin
      n_bad++; $display("FAIL spur_latency: got %0d want %0d", resp_edge - s, BEATS + 1);
    end
    e = exp_line_q.pop_front();
    n_cmp++;
    if (resp_line !== e) begin
      n_bad++; $display("FAIL spur_line: got %h want %h", resp_line, e);
    end
  endtask

  task automatic test_fill_hit();
    int s, sr, rc0, want_lat, want_rc;
    bit to;
    logic [LW-1:0] e, l;
    // Fill 0x1220 from memory.
    set_rd_random();
    push_rd_exp();
    sr = n_resp;
    issue(1'b1, 1'b0, 32'h0000_1234, '0);
    wait_resp(sr, to);
    bus.c_read_i = 1'b0;
    tick();
    e = exp_line_q.pop_front();
    n_cmp++;
    if (to || resp_line !== e) begin
      n_bad++; $display("FAIL fill_first_line: got %h want %h", resp_line, e);
    end
    // Repeat the read of the same line.
    push_rd_exp();
`ifdef FILL_BUFFER_HIT_EN
    want_lat = 1; want_rc = 0;
`else
    want_lat = BEATS + 1; want_rc = BEATS;
`endif
    s = edges; sr = n_resp; rc0 = rd_cycles;
    issue(1'b1, 1'b0, 32'h0000_1220, '0);
    wait_resp(sr, to);
    bus.c_read_i = 1'b0;
    tick();
    n_cmp++;
    if (to || resp_edge - s != want_lat) begin
      n_bad++; $display("FAIL fill_repeat_latency: got %0d want %0d", resp_edge - s, want_lat);
    end
    n_cmp++;
    if (rd_cycles - rc0 != want_rc) begin
      n_bad++; $display("FAIL fill_repeat_m_read: got %0d want %0d", rd_cycles - rc0, want_rc);
    end
    e = exp_line_q.pop_front();
    n_cmp++;
    if (resp_line !== e) begin
      n_bad++; $display("FAIL fill_repeat_line: got %h want %h", resp_line, e);
    end
    // Write the tagged line, then read it again: must go to memory.
    l = {8{$urandom()}};
    sr = n_resp;
    issue(1'b0, 1'b1, 32'h0000_1220, l);
    wait_resp(sr, to);
    bus.c_write_i = 1'b0;
    tick();
    wr_log.delete();
    set_rd_random();
    push_rd_exp();
    s = edges; sr = n_resp; rc0 = rd_cycles;
    issue(1'b1, 1'b0, 32'h0000_1220, '0);
    wait_resp(sr, to);
    bus.c_read_i = 1'b0;
    tick();
    n_cmp++;
    if (to || resp_edge - s != BEATS + 1 || rd_cycles - rc0 != BEATS) begin
      n_bad++; $display("FAIL fill_after_write_burst: got lat=%0d rd=%0d want %0d %0d",
                        resp_edge - s, rd_cycles - rc0, BEATS + 1, BEATS);
    end
    e = exp_line_q.pop_front();
    n_cmp++;
    if (resp_line !== e) begin
      n_bad++; $display("FAIL fill_after_write_line: got %h want %h", resp_line, e);
    end
  endtask

  task automatic test_exclusive_outputs();
    n_cmp++;
    if (onehot_err != 0) begin
      n_bad++; $display("FAIL exclusive_outputs: got %0d overlaps want 0", onehot_err);
    end
  endtask

  initial begin
    bus.c_addr_i  = '0;
    bus.c_read_i  = 1'b0;
    bus.c_write_i = 1'b0;
    bus.c_line_i  = '0;
    bus.m_burst_i = '0;
    bus.m_resp_i  = 1'b0;
    for (int i = 0; i < BEATS; i++) rd_data[i] = '0;
    test_reset();
    test_read_zero_wait();
    test_write_gaps();
    test_read_write_together();
    test_reset_mid_burst();
    test_spurious_idle();
    test_fill_hit();
    test_exclusive_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
